// File: rtl/design_switch_pkg.sv
// Shared types and constants for the design-switch controller.
package design_switch_pkg;

  localparam int DESIGN_IDX_W = 4;
  localparam logic [DESIGN_IDX_W-1:0] DESIGN_NONE = 4'd0;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ISOLATE,
    ST_RESET,
    ST_RUN
  } switch_state_e;

  // Out-of-range indices collapse to "no design" so the pads end up parked.
  function automatic logic [DESIGN_IDX_W-1:0] legal_select(
    input logic [DESIGN_IDX_W-1:0] sel,
    input logic [DESIGN_IDX_W-1:0] max_idx
  );
    return (sel > max_idx) ? DESIGN_NONE : sel;
  endfunction

endpackage

// File: rtl/design_switch_ctrl_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/design_switch_ctrl.sv
// Sequences glitch-free hand-over of the shared pad ring between student designs.
// Optional switch statistics counter enabled by defining DESIGN_SWITCH_STATS_EN.
module design_switch_ctrl
  import design_switch_pkg::*;
#(
  parameter int NUM_PROJECTS = 13,
  parameter int ISO_CYCLES   = 4,
  parameter int RST_CYCLES   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [DESIGN_IDX_W-1:0] req_select,
  output logic                    busy,
  output logic                    req_drop,
  output logic                    sel_err,
  output logic [DESIGN_IDX_W-1:0] active_select,
  output logic                    pad_isolate,
  output logic                    design_rst,
  output logic [7:0]              switch_count
);

  localparam int PHASE_MAX = (ISO_CYCLES > RST_CYCLES) ? ISO_CYCLES : RST_CYCLES;
  localparam int CNT_W     = $clog2(PHASE_MAX) + 1;
  localparam logic [DESIGN_IDX_W-1:0] MAX_IDX = DESIGN_IDX_W'(NUM_PROJECTS);

  switch_state_e           state_q, state_d;
  logic [DESIGN_IDX_W-1:0] target_q, target_d;
  logic [DESIGN_IDX_W-1:0] active_select_q, active_select_d;
  logic                    pad_isolate_q, pad_isolate_d;
  logic                    design_rst_q, design_rst_d;
  logic                    busy_q, busy_d;
  logic                    req_drop_q, req_drop_d;
  logic                    sel_err_q, sel_err_d;

  logic [DESIGN_IDX_W-1:0] req_idx;
  logic                    start_seq;
  logic                    timer_load;
  logic [CNT_W-1:0]        timer_val;
  logic                    timer_done;

  assign req_idx = legal_select(req_select, MAX_IDX);

  phase_timer #(
    .WIDTH (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d         = state_q;
    target_d        = target_q;
    active_select_d = active_select_q;
    pad_isolate_d   = pad_isolate_q;
    design_rst_d    = design_rst_q;
    busy_d          = busy_q;
    timer_load      = 1'b0;
    timer_val       = '0;
    start_seq       = 1'b0;
    req_drop_d      = req_valid && busy_q;
    sel_err_d       = sel_err_q || (req_valid && (req_select > MAX_IDX));

    unique case (state_q)
      ST_OFF:  start_seq = req_valid && (req_idx != DESIGN_NONE);
      ST_RUN:  start_seq = req_valid && (req_idx != active_select_q);
      ST_ISOLATE: begin
        // The mux only moves here, while the pads are still isolated.
        if (timer_done) begin
          if (target_q != DESIGN_NONE) begin
            state_d         = ST_RESET;
            active_select_d = target_q;
            design_rst_d    = 1'b1;
            timer_load      = 1'b1;
            timer_val       = CNT_W'(RST_CYCLES - 1);
          end else begin
            state_d         = ST_OFF;
            active_select_d = DESIGN_NONE;
            design_rst_d    = 1'b1;
            busy_d          = 1'b0;
          end
        end
      end
      ST_RESET: begin
        if (timer_done) begin
          state_d       = ST_RUN;
          pad_isolate_d = 1'b0;
          design_rst_d  = 1'b0;
          busy_d        = 1'b0;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // The outgoing design keeps its current reset level during isolation.
    if (start_seq) begin
      state_d       = ST_ISOLATE;
      target_d      = req_idx;
      pad_isolate_d = 1'b1;
      busy_d        = 1'b1;
      timer_load    = 1'b1;
      timer_val     = CNT_W'(ISO_CYCLES - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_OFF;
      target_q        <= DESIGN_NONE;
      active_select_q <= DESIGN_NONE;
      pad_isolate_q   <= 1'b1;
      design_rst_q    <= 1'b1;
      busy_q          <= 1'b0;
      req_drop_q      <= 1'b0;
      sel_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      active_select_q <= active_select_d;
      pad_isolate_q   <= pad_isolate_d;
      design_rst_q    <= design_rst_d;
      busy_q          <= busy_d;
      req_drop_q      <= req_drop_d;
      sel_err_q       <= sel_err_d;
    end
  end

  assign busy          = busy_q;
  assign req_drop      = req_drop_q;
  assign sel_err       = sel_err_q;
  assign active_select = active_select_q;
  assign pad_isolate   = pad_isolate_q;
  assign design_rst    = design_rst_q;

`ifdef DESIGN_SWITCH_STATS_EN
  logic [7:0] switch_count_q, switch_count_d;
  logic       seq_done;

  // RUN and OFF are only ever entered at the end of a sequence.
  assign seq_done = (state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_OFF));

  always_comb begin
    switch_count_d = switch_count_q;
    if (seq_done && (switch_count_q != 8'hFF)) begin
      switch_count_d = switch_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      switch_count_q <= 8'd0;
    end else begin
      switch_count_q <= switch_count_d;
    end
  end

  assign switch_count = switch_count_q;
`else
  assign switch_count = 8'd0;
`endif

endmodule
